dco_freq_meter: RTL and testbench

//  Gated edge-counting frequency meter sitting directly downstream of the DCO.

---
 rtl/dco_freq_meter.sv | 153 +++++++++++++++
 tb/tb_dco_freq_meter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dco_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : dco_freq_meter
// Description : Gated rising-edge counter measuring sig_in over gate_len clk
//               cycles, with one-shot and back-to-back continuous modes.
// Revision    : 1.0 - initial release
// ============================================================================
module dco_freq_meter #(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sig_in,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [GATE_W-1:0] gate_len,
    output logic              busy,
    output logic [CNT_W-1:0]  count,
    output logic              count_valid,
    output logic              overflow
);

    localparam logic [CNT_W-1:0]  C_CNT_MAX    = '1;
    localparam logic [GATE_W-1:0] C_TIMER_LAST = GATE_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_GATE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [SYNC_STAGES-1:0] r_sync;
    logic               w_s_last;
    logic               r_prev;
    logic               w_edge;

    logic [GATE_W-1:0]  r_gate_len_q;
    logic [GATE_W-1:0]  r_timer;
    logic [CNT_W-1:0]   r_edge_cnt;
    logic               r_sat;
    logic [CNT_W-1:0]   r_count;
    logic               r_count_valid;
    logic               r_overflow;

    logic               w_accept;
    logic               w_abort;
    logic               w_done;
    logic               w_cnt_at_max;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_sat_next;

    // sig_in may be asynchronous to clk; resynchronise before edge detection
    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_sync <= '0;
                else       r_sync <= sig_in;
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_sync <= '0;
                else       r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            end
        end
    endgenerate

    assign w_s_last = r_sync[SYNC_STAGES-1];
    assign w_edge   = w_s_last & ~r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= w_s_last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_abort      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!stop && start && (gate_len != '0)) begin
                    w_accept     = 1'b1;
                    w_state_next = S_GATE;
                end
            end
            S_GATE: begin
                if (stop) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_timer == C_TIMER_LAST) begin
                    w_done = 1'b1;
                    if (!continuous) w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Saturating count: the flag records that at least one edge was lost
    assign w_cnt_at_max = (r_edge_cnt == C_CNT_MAX);
    assign w_cnt_next   = (w_edge && !w_cnt_at_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
    assign w_sat_next   = r_sat | (w_edge & w_cnt_at_max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gate_len_q  <= '0;
            r_timer       <= '0;
            r_edge_cnt    <= '0;
            r_sat         <= 1'b0;
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_count_valid <= 1'b0;
            if (w_accept) begin
                r_gate_len_q <= gate_len;
                r_timer      <= gate_len;
                r_edge_cnt   <= '0;
                r_sat        <= 1'b0;
            end else if (w_done) begin
                // Reload unconditionally so continuous mode re-arms with no dead cycle
                r_count       <= w_cnt_next;
                r_overflow    <= w_sat_next;
                r_count_valid <= 1'b1;
                r_timer       <= r_gate_len_q;
                r_edge_cnt    <= '0;
                r_sat         <= 1'b0;
            end else if ((r_state == S_GATE) && !w_abort) begin
                r_timer    <= r_timer - GATE_W'(1);
                r_edge_cnt <= w_cnt_next;
                r_sat      <= w_sat_next;
            end
        end
    end

    assign busy        = (r_state == S_GATE);
    assign count       = r_count;
    assign count_valid = r_count_valid;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dco_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dco_freq_meter
// Description : Self-checking bench for dco_freq_meter against a window-level
//               edge-counting model, plus directed literal scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dco_freq_meter;

    localparam int CNT_W       = 8;
    localparam int GATE_W      = 16;
    localparam int SYNC_STAGES = 2;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              sig_in;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              continuous = 1'b0;
    logic [GATE_W-1:0] gate_len = '0;
    logic              busy;
    logic [CNT_W-1:0]  count;
    logic              count_valid;
    logic              overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    dco_freq_meter #(
        .CNT_W       (CNT_W),
        .GATE_W      (GATE_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sig_in      (sig_in),
        .start       (start),
        .stop        (stop),
        .continuous  (continuous),
        .gate_len    (gate_len),
        .busy        (busy),
        .count       (count),
        .count_valid (count_valid),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Signal source: 0 low, 1 period 2, 2 period 4, 3 random, 4 manual
    int         sig_mode = 0;
    logic       sig_gen = 1'b0;
    logic       sig_manual = 1'b0;
    logic [1:0] ph = 2'd0;
    assign sig_in = (sig_mode == 4) ? sig_manual : sig_gen;

    always @(negedge clk) begin
        case (sig_mode)
            1: sig_gen = ~sig_gen;
            2: begin ph = ph + 2'd1; sig_gen = ph[1]; end
            3: sig_gen = 1'($urandom_range(0, 1));
            default: sig_gen = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Window-level model: a rising edge of sig_in sampled at posedge j is seen by
    // the window logic at posedge j+SYNC_STAGES; a window accumulates L such edges.
    bit [7:0]         hist = '0;
    bit               m_active = 1'b0;
    int               m_rem = 0, m_glen = 0, m_acc = 0;
    logic             exp_busy = 1'b0, exp_valid = 1'b0, exp_ovf = 1'b0;
    logic [CNT_W-1:0] exp_count = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist = '0; m_active = 1'b0; m_acc = 0; m_rem = 0;
            exp_busy = 1'b0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_count = '0;
        end else begin
            bit e;
            e = hist[SYNC_STAGES-1] & ~hist[SYNC_STAGES];
            hist = {hist[6:0], sig_in};
            exp_valid = 1'b0;
            if (!m_active) begin
                if (!stop && start && gate_len != 0) begin
                    m_active = 1'b1; m_glen = int'(gate_len); m_rem = m_glen; m_acc = 0;
                end
            end else begin
                m_acc += int'(e);
                if (stop) m_active = 1'b0;
                else if (m_rem == 1) begin
                    exp_count = (m_acc > CMAX) ? CNT_W'(CMAX) : CNT_W'(m_acc);
                    exp_ovf   = (m_acc > CMAX);
                    exp_valid = 1'b1;
                    if (continuous) begin m_rem = m_glen; m_acc = 0; end
                    else m_active = 1'b0;
                end else m_rem--;
            end
            exp_busy = m_active;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("count_valid", {31'd0, count_valid}, {31'd0, exp_valid});
            check("count", 32'(count), 32'(exp_count));
            check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        end
    end

    // k is the cycle index of the accepting posedge; the strobe is then seen L later
    task automatic do_start(input int len, input bit cont, output int k);
        @(negedge clk);
        gate_len = GATE_W'(len); continuous = cont; start = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_strobe(input string name, input int limit, output int at);
        bit got;
        got = 1'b0; at = -1;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (count_valid) begin got = 1'b1; at = cyc; end
        end
        if (!got) check({name, " timeout"}, 32'd0, 32'd1);
    endtask

    task automatic count_strobes(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (count_valid) n++;
        end
    endtask

    initial begin
        #(400000);
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int k, t, t1, t2, t3, n;
        #2 reset = 1'b1;
        #1 check("reset busy", {31'd0, busy}, 32'd0);
        check("reset count", 32'(count), 32'd0);
        check("reset valid", {31'd0, count_valid}, 32'd0);
        check("reset ovf", {31'd0, overflow}, 32'd0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        // One-shot, period 4, 100-cycle window
        sig_mode = 2;
        repeat (8) @(negedge clk);
        do_start(100, 1'b0, k);
        wait_strobe("t1", 150, t);
        check("t1 latency", 32'(t - k), 32'd100);
        check("t1 count", 32'(count), 32'd25);
        check("t1 ovf", {31'd0, overflow}, 32'd0);
        check("t1 busy at strobe", {31'd0, busy}, 32'd0);
        count_strobes(30, n);
        check("t1 extra strobes", 32'(n), 32'd0);

        // Saturation, then a clean zero-count run
        sig_mode = 1;
        do_start(600, 1'b0, k);
        wait_strobe("t2a", 650, t);
        check("t2 sat count", 32'(count), 32'(CMAX));
        check("t2 sat ovf", {31'd0, overflow}, 32'd1);
        sig_mode = 0;
        repeat (5) @(negedge clk);
        do_start(50, 1'b0, k);
        wait_strobe("t2b", 80, t);
        check("t2 zero count", 32'(count), 32'd0);
        check("t2 zero ovf", {31'd0, overflow}, 32'd0);

        // Continuous, strobes back-to-back, then stop mid-window
        sig_mode = 2;
        do_start(40, 1'b1, k);
        wait_strobe("t3a", 60, t1);
        check("t3 first", 32'(t1 - k), 32'd40);
        check("t3 count1", 32'(count), 32'd10);
        wait_strobe("t3b", 60, t2);
        check("t3 spacing1", 32'(t2 - t1), 32'd40);
        check("t3 count2", 32'(count), 32'd10);
        wait_strobe("t3c", 60, t3);
        check("t3 spacing2", 32'(t3 - t2), 32'd40);
        repeat (15) @(negedge clk);
        stop = 1'b1; continuous = 1'b0;
        @(negedge clk);
        stop = 1'b0;
        check("t3 busy after stop", {31'd0, busy}, 32'd0);
        count_strobes(100, n);
        check("t3 strobes after stop", 32'(n), 32'd0);
        check("t3 count held", 32'(count), 32'd10);

        // Ignored starts
        @(negedge clk); gate_len = '0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("t4 gate0 busy", {31'd0, busy}, 32'd0);
        gate_len = GATE_W'(20); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        check("t4 start+stop busy", {31'd0, busy}, 32'd0);
        do_start(30, 1'b0, k);
        repeat (10) @(negedge clk);
        gate_len = GATE_W'(5); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_strobe("t4", 60, t);
        check("t4 window unchanged", 32'(t - k), 32'd30);

        // Edge exactly in the single gate cycle vs one cycle late
        sig_mode = 4; sig_manual = 1'b0;
        repeat (6) @(negedge clk);
        sig_manual = 1'b1;
        do_start(1, 1'b0, k);
        wait_strobe("t5a", 10, t);
        check("t5 edge in window", 32'(count), 32'd1);
        sig_manual = 1'b0;
        repeat (6) @(negedge clk);
        sig_manual = 1'b1; gate_len = GATE_W'(1); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_strobe("t5b", 10, t);
        check("t5 edge after window", 32'(count), 32'd0);

        // Reset mid-window
        sig_mode = 2;
        do_start(20, 1'b0, k);
        wait_strobe("t6a", 40, t);
        check("t6 pre count", 32'(count), 32'd5);
        do_start(100, 1'b0, k);
        repeat (30) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("t6 busy in reset", {31'd0, busy}, 32'd0);
        check("t6 count in reset", 32'(count), 32'd0);
        check("t6 valid in reset", {31'd0, count_valid}, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        count_strobes(110, n);
        check("t6 no strobe", 32'(n), 32'd0);
        do_start(100, 1'b0, k);
        wait_strobe("t6b", 150, t);
        check("t6 count", 32'(count), 32'd25);

        // Randomised traffic, checked every cycle by the model
        for (int trial = 0; trial < 40; trial++) begin
            int cyc_n;
            sig_mode = $urandom_range(0, 3);
            do_start($urandom_range(1, 50), ($urandom_range(0, 2) == 0), k);
            cyc_n = $urandom_range(10, 120);
            for (int i = 0; i < cyc_n; i++) begin
                @(negedge clk);
                start    = ($urandom_range(0, 7) == 0);
                stop     = ($urandom_range(0, 39) == 0);
                gate_len = GATE_W'($urandom_range(0, 40));
            end
            @(negedge clk);
            start = 1'b0; stop = 1'b1; continuous = 1'b0;
            @(negedge clk);
            stop = 1'b0;
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
